// File: rtl/uart_txn_ctrl.sv
// uart_txn_ctrl: command/response transaction sequencer in front of a UART FIFO pair.
//
// A start pulse in IDLE sends a command byte stream to the UART TX FIFO. The transaction then
// forwards received bytes until the PROMPT terminator arrives, an inter-byte timeout expires,
// a line error is flagged, or the response cap is exceeded.
//
// Ports
//   clk, reset                         clock, asynchronous active-high reset
//   start                              transaction request pulse (honoured only in IDLE)
//   cmd_data/cmd_valid/cmd_last        command byte stream in; cmd_ready is its handshake
//   rsp_data/rsp_valid                 forwarded response bytes (single-cycle, no backpressure)
//   busy, done_tick, err_tick          status; err_code 00 none, 01 timeout, 10 line, 11 overflow
//   rsp_count                          number of response bytes forwarded this transaction
//   tx_full/wr_uart/w_data             UART TX FIFO write side
//   rx_empty/rd_uart/r_data/e_line     UART RX FIFO read side; e_line is parity OR frame error
//
// Build option: define UART_TXN_CR_STRIP_EN to silently consume received 8'h0D bytes.
module uart_txn_ctrl #(
  parameter logic [7:0]  PROMPT  = 8'h3E,
  parameter int unsigned TIMEOUT = 500000,
  parameter int unsigned TO_BIT  = 19,
  parameter int unsigned MAX_RSP = 64,
  parameter int unsigned RSP_BIT = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_valid,
  input  logic               cmd_last,
  output logic               cmd_ready,
  output logic [7:0]         rsp_data,
  output logic               rsp_valid,
  output logic               busy,
  output logic               done_tick,
  output logic               err_tick,
  output logic [1:0]         err_code,
  output logic [RSP_BIT-1:0] rsp_count,
  input  logic               tx_full,
  output logic               wr_uart,
  output logic [7:0]         w_data,
  input  logic               rx_empty,
  output logic               rd_uart,
  input  logic [7:0]         r_data,
  input  logic               e_line
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEND = 3'd1;
  localparam logic [2:0] RECV = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [TO_BIT-1:0]  TO_LOAD = TO_BIT'(TIMEOUT - 1);
  localparam logic [RSP_BIT-1:0] RSP_CAP = RSP_BIT'(MAX_RSP);

  logic [2:0]         state_q, state_d;
  logic [TO_BIT-1:0]  timer_q, timer_d;
  logic [RSP_BIT-1:0] rsp_count_q, rsp_count_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               rd_req;
  logic               strip_cr;

`ifdef UART_TXN_CR_STRIP_EN
  assign strip_cr = (r_data == 8'h0D);
`else
  assign strip_cr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rsp_count_d = rsp_count_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    err_code_d  = err_code_q;
    cmd_ready   = 1'b0;
    wr_uart     = 1'b0;
    rd_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Drain stale RX bytes so they never leak into the next response.
        rd_req = !rx_empty;
        if (start) begin
          state_d     = SEND;
          rsp_count_d = '0;
          err_code_d  = 2'b00;
        end
      end
      SEND: begin
        cmd_ready = !tx_full;
        wr_uart   = cmd_valid && !tx_full;
        if (cmd_valid && !tx_full && cmd_last) begin
          state_d = RECV;
          timer_d = TO_LOAD;
        end
      end
      RECV: begin
        rd_req = !rx_empty;
        if (e_line) begin
          // Line error wins over any byte read in the same cycle.
          state_d    = ERR;
          err_code_d = 2'b10;
        end else if (!rx_empty) begin
          timer_d = TO_LOAD;
          if (r_data == PROMPT) begin
            state_d = DONE;
          end else if (strip_cr) begin
            state_d = RECV;
          end else if (rsp_count_q == RSP_CAP) begin
            state_d    = ERR;
            err_code_d = 2'b11;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = r_data;
            rsp_count_d = rsp_count_q + 1'b1;
          end
        end else if (timer_q == '0) begin
          state_d    = ERR;
          err_code_d = 2'b01;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      rsp_count_q <= '0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rsp_count_q <= rsp_count_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  // IDLE flushes RX, so reset must gate the read strobe to keep the FIFO untouched.
  assign rd_uart   = rd_req && !reset;
  assign w_data    = cmd_data;
  assign busy      = (state_q != IDLE);
  assign done_tick = (state_q == DONE);
  assign err_tick  = (state_q == ERR);
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_count = rsp_count_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_txn_ctrl.sv
module tb_uart_txn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] cmd_data;
  logic       cmd_valid, cmd_last, cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid, busy, done_tick, err_tick;
  logic [1:0] err_code;
  logic [6:0] rsp_count;
  logic       tx_full, wr_uart, rx_empty, rd_uart, e_line;
  logic [7:0] w_data, r_data;

  always #5 clk = ~clk;

  uart_txn_ctrl #(.TIMEOUT(100), .MAX_RSP(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_last(cmd_last), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .busy(busy), .done_tick(done_tick),
    .err_tick(err_tick), .err_code(err_code), .rsp_count(rsp_count),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
    .rx_empty(rx_empty), .rd_uart(rd_uart), .r_data(r_data), .e_line(e_line)
  );

  // Command source: bytes queued by the stimulus, popped on each accepted write.
  logic [7:0]  cmd_mem [64];
  int unsigned cmd_wr = 0;
  int unsigned cmd_rd = 0;
  assign cmd_valid = (cmd_rd != cmd_wr);
  assign cmd_data  = cmd_mem[cmd_rd[5:0]];
  assign cmd_last  = (cmd_rd + 1 == cmd_wr);
  always @(posedge clk) if (wr_uart) cmd_rd <= cmd_rd + 1;

  // RX FIFO model: popped on each read strobe.
  logic [7:0]  rx_mem [64];
  int unsigned rx_wr = 0;
  int unsigned rx_rd = 0;
  assign rx_empty = (rx_rd == rx_wr);
  assign r_data   = rx_mem[rx_rd[5:0]];
  always @(posedge clk) if (rd_uart && !rx_empty) rx_rd <= rx_rd + 1;

  // Output monitor, sampled on the falling edge.
  logic [7:0] wr_log  [64];
  logic [7:0] rsp_log [64];
  int wr_n = 0, rsp_n = 0, done_n = 0, err_n = 0;
  always @(negedge clk) begin
    if (wr_uart) begin
      wr_log[wr_n[5:0]] <= w_data;
      wr_n <= wr_n + 1;
    end
    if (rsp_valid) begin
      rsp_log[rsp_n[5:0]] <= rsp_data;
      rsp_n <= rsp_n + 1;
    end
    if (done_tick) done_n <= done_n + 1;
    if (err_tick)  err_n  <= err_n + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [7:0] b);
    cmd_mem[cmd_wr[5:0]] = b;
    cmd_wr++;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[5:0]] = b;
    rx_wr++;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Wait (bounded) until done_tick or err_tick is seen on a falling edge.
  task automatic wait_end(input int budget, output logic seen);
    int k;
    seen = 1'b0;
    k = 0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      seen = done_tick || err_tick;
    end
  endtask

  int   wb, rb, db, eb, k;
  logic seen;
  int   exp_rsp;

  initial begin
    reset = 1'b1; start = 1'b0; tx_full = 1'b0; e_line = 1'b0;
    push_rx(8'hAA);
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",      32'(busy), 0);
    check("rst_done",      32'(done_tick), 0);
    check("rst_err",       32'(err_tick), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_wr_uart",   32'(wr_uart), 0);
    check("rst_rd_uart",   32'(rd_uart), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_err_code",  32'(err_code), 0);
    check("rst_rsp_count", 32'(rsp_count), 0);
    check("rst_rsp_data",  32'(rsp_data), 0);
    @(negedge clk) reset = 1'b0;

    // Stale RX bytes in IDLE are flushed, never forwarded.
    push_rx(8'h11); push_rx(8'h22);
    repeat (5) @(negedge clk);
    #1;
    check("flush_rx_empty", 32'(rx_empty), 1);
    check("flush_no_rsp",   32'(rsp_n), 0);
    check("idle_cmd_ready", 32'(cmd_ready), 0);

    // "AT\r" -> "OK\r>"
    wb = wr_n; rb = rsp_n; db = done_n; eb = err_n;
    push_cmd(8'h41); push_cmd(8'h54); push_cmd(8'h0D);
    pulse_start();
    check("at_busy", 32'(busy), 1);
    push_rx(8'h4F); push_rx(8'h4B); push_rx(8'h0D); push_rx(8'h3E);
    wait_end(50, seen);
    check("at_end_seen", 32'(seen), 1);
    check("at_done_tick", 32'(done_tick), 1);
`ifdef UART_TXN_CR_STRIP_EN
    exp_rsp = 2;
`else
    exp_rsp = 3;
`endif
    check("at_rsp_count", 32'(rsp_count), 32'(exp_rsp));
    check("at_err_code", 32'(err_code), 0);
    @(negedge clk); #1;
    check("at_wr_n", 32'(wr_n - wb), 3);
    check("at_w0", 32'(wr_log[wb]), 32'h41);
    check("at_w1", 32'(wr_log[wb+1]), 32'h54);
    check("at_w2", 32'(wr_log[wb+2]), 32'h0D);
    check("at_rsp_n", 32'(rsp_n - rb), 32'(exp_rsp));
    check("at_r0", 32'(rsp_log[rb]), 32'h4F);
    check("at_r1", 32'(rsp_log[rb+1]), 32'h4B);
`ifndef UART_TXN_CR_STRIP_EN
    check("at_r2", 32'(rsp_log[rb+2]), 32'h0D);
`endif
    check("at_done_n", 32'(done_n - db), 1);
    check("at_busy_after", 32'(busy), 0);

    // TX backpressure for 5 cycles in the middle of "ABCD".
    wb = wr_n; rb = rsp_n;
    push_cmd(8'h41); push_cmd(8'h42); push_cmd(8'h43); push_cmd(8'h44);
    pulse_start();
    @(negedge clk);
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_cmd_ready", 32'(cmd_ready), 0);
      check("bp_wr_uart", 32'(wr_uart), 0);
      @(negedge clk);
    end
    tx_full = 1'b0;
    push_rx(8'h3E);
    wait_end(50, seen);
    check("bp_done", 32'(done_tick), 1);
    @(negedge clk); #1;
    check("bp_wr_n", 32'(wr_n - wb), 4);
    check("bp_w0", 32'(wr_log[wb]), 32'h41);
    check("bp_w1", 32'(wr_log[wb+1]), 32'h42);
    check("bp_w2", 32'(wr_log[wb+2]), 32'h43);
    check("bp_w3", 32'(wr_log[wb+3]), 32'h44);
    check("bp_rsp_n", 32'(rsp_n - rb), 0);

    // Timeout: no RX after a one-byte command.
    push_cmd(8'h54);
    pulse_start();
    k = 0;
    while (!err_tick && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("to_cycles_after_recv", 32'(k - 1), 100);
    check("to_err_code", 32'(err_code), 1);
    check("to_done_tick", 32'(done_tick), 0);
    @(negedge clk); #1;
    check("to_err_code_hold", 32'(err_code), 1);

    // Line error coincident with a byte read.
    rb = rsp_n;
    push_cmd(8'h45);
    pulse_start();
    @(negedge clk);
    push_rx(8'h55);
    e_line = 1'b1;
    @(negedge clk);
    e_line = 1'b0;
    #1;
    check("le_err_tick", 32'(err_tick), 1);
    check("le_err_code", 32'(err_code), 2);
    check("le_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk); #1;
    check("le_rsp_n", 32'(rsp_n - rb), 0);
    check("le_rx_empty", 32'(rx_empty), 1);

    // Overflow: 5 bytes with a cap of 4.
    rb = rsp_n;
    push_cmd(8'h4F);
    pulse_start();
    push_rx(8'h31); push_rx(8'h32); push_rx(8'h33); push_rx(8'h34); push_rx(8'h35);
    wait_end(50, seen);
    check("ov_err_tick", 32'(err_tick), 1);
    check("ov_err_code", 32'(err_code), 3);
    check("ov_rsp_count", 32'(rsp_count), 4);
    @(negedge clk); #1;
    check("ov_rsp_n", 32'(rsp_n - rb), 4);
    check("ov_r0", 32'(rsp_log[rb]), 32'h31);
    check("ov_r3", 32'(rsp_log[rb+3]), 32'h34);

    // Reset while in RECV aborts silently.
    push_cmd(8'h52);
    pulse_start();
    @(negedge clk);
    reset = 1'b1;
    push_rx(8'h77);
    db = done_n; eb = err_n;
    #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_rd_uart", 32'(rd_uart), 0);
    check("mr_rsp_data", 32'(rsp_data), 0);
    check("mr_rsp_count", 32'(rsp_count), 0);
    check("mr_err_code", 32'(err_code), 0);
    check("mr_ticks", 32'({done_tick, err_tick}), 0);
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("mr_no_done", 32'(done_n - db), 0);
    check("mr_no_err", 32'(err_n - eb), 0);
    check("mr_flushed", 32'(rx_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_txn_ctrl.md
UART_TXN_CTRL -- requirements
Module: uart_txn_ctrl

Interface
REQ-001 SHALL have parameter PROMPT, default 8'h3E, the response terminator byte.
REQ-002 SHALL have parameter TIMEOUT, default 500000, the inter-byte receive timeout in clk cycles.
REQ-003 SHALL have parameter TO_BIT, default 19, the timeout counter width.
REQ-004 SHALL have parameter MAX_RSP, default 64, the response byte cap; RSP_BIT, default 7, is the rsp_count width.
REQ-005 SHALL have port clk, input, 1, system clock, with all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, transaction request pulse.
REQ-008 SHALL have ports cmd_data, input, 8; cmd_valid, input, 1; cmd_last, input, 1; cmd_ready, output, 1: the command byte stream.
REQ-009 SHALL have ports rsp_data, output, 8, and rsp_valid, output, 1: the response byte stream, with no backpressure.
REQ-010 SHALL have ports busy, done_tick, err_tick, all output, 1, and err_code, output, 2 (00 none, 01 timeout, 10 line error, 11 overflow).
REQ-011 SHALL have port rsp_count, output, RSP_BIT, the number of forwarded response bytes.
REQ-012 SHALL have UART-side ports: tx_full, input, 1; wr_uart, output, 1; w_data, output, 8; rx_empty, input, 1; rd_uart, output, 1; r_data, input, 8; e_line, input, 1 (parity OR frame error).

Function
REQ-013 SHALL implement the states IDLE, SEND, RECV, DONE and ERR.
REQ-014 IDLE SHALL drive busy=0 and cmd_ready=0, and SHALL drive rd_uart=!rx_empty to flush stale RX bytes without forwarding them.
REQ-015 start in IDLE SHALL enter SEND on the next cycle, clear rsp_count and set err_code=00; start outside IDLE SHALL be ignored.
REQ-016 SEND SHALL combinationally drive cmd_ready=!tx_full, wr_uart=cmd_valid&&!tx_full and w_data=cmd_data, so the first write can occur in the cycle after start.
REQ-017 A SEND transfer with cmd_last=1 SHALL enter RECV and load the timer with TIMEOUT-1.
REQ-018 RECV SHALL drive rd_uart=!rx_empty and capture r_data in the same cycle.
REQ-019 A captured non-PROMPT byte SHALL appear on rsp_data with rsp_valid=1 for exactly one cycle, one cycle after rd_uart, and SHALL increment rsp_count.
REQ-020 A captured PROMPT byte SHALL NOT be forwarded and SHALL enter DONE.
REQ-021 The timer SHALL reload on every byte read and decrement otherwise; reaching 0 with rx_empty=1 SHALL enter ERR with err_code=01.
REQ-022 e_line=1 in RECV SHALL enter ERR with err_code=10, with priority over a byte read in the same cycle.
REQ-023 A non-PROMPT byte arriving when rsp_count==MAX_RSP SHALL NOT be forwarded and SHALL enter ERR with err_code=11; rsp_count SHALL never wrap.
REQ-024 DONE SHALL pulse done_tick for one cycle and then return to IDLE.
REQ-025 ERR SHALL pulse err_tick for one cycle and then return to IDLE; err_code SHALL hold until the next accepted start.
REQ-026 busy SHALL be 1 in SEND, RECV, DONE and ERR.

Reset
REQ-027 Reset SHALL force IDLE with busy, done_tick, err_tick, rsp_valid, wr_uart, rd_uart and cmd_ready all 0, err_code=00, rsp_count=0, rsp_data=8'h00 and the timer at 0.
REQ-028 Reset mid-transaction SHALL abort with no done_tick or err_tick.

Configuration
REQ-029 With UART_TXN_CR_STRIP_EN defined, captured 8'h0D bytes SHALL be consumed but neither forwarded nor counted; without it, they SHALL be treated as ordinary bytes.

Verification
REQ-030 start, cmd "AT\r" (cmd_last on 8'h0D), tx_full=0 -> 3 wr_uart pulses with w_data 41,54,0D; rx "OK\r>" -> rsp 4F,4B,0D (4F,4B with CR_STRIP), then done_tick, rsp_count=3 (2).
REQ-031 tx_full=1 for 5 cycles mid-command -> cmd_ready=0 and wr_uart=0 for those cycles, with no byte lost or duplicated.
REQ-032 TIMEOUT=100, no rx after the command -> err_tick exactly 100 cycles after entering RECV, err_code=01.
REQ-033 e_line=1 coincident with a byte in RECV -> err_code=10, byte not forwarded.
REQ-034 MAX_RSP=4, 5 bytes without PROMPT -> 4 rsp_valid pulses, then err_code=11.
REQ-035 2 stale RX bytes in IDLE -> both flushed, rsp_valid stays 0; reset asserted in RECV -> IDLE with all outputs 0.
